uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N2 serial transmitter.
//
// Bytes arrive on a valid/ready port, are queued in a circular FIFO of 2**DEPTH_LOG2 entries and
// are serialised on txd, LSB first, followed by two stop bits. Frames are sent back to back while
// the FIFO has data.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit between the data bits
// and the first stop bit (frame grows from 11 to 12 bit times).
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_data     byte to transmit
//   in_valid    producer has a byte on in_data
//   in_ready    FIFO not full; a byte is taken when in_valid && in_ready at a rising edge
//   txd         registered serial output, idles high
//   busy        FIFO non-empty or frame on the line
//   fifo_count  queued bytes, excluding the frame being shifted
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  txd,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_count
);

  // Clocks per bit, rounded to nearest; must be >= 2.
  localparam int unsigned DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop1,
    StStop2
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------------------------
  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;
  logic                full, empty, push, pop;
  logic [7:0]          head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign in_ready   = ~full;
  assign push       = in_valid & ~full;
  assign head       = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign fifo_count = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             txd_q, line_d;
  logic             busy_q;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    line_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = '0;
          state_d = StStart;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      StStart: begin
        line_d = 1'b0;
        if (bit_end) begin
          idx_d   = 3'd0;
          state_d = StData;
        end
      end
      StData: begin
        line_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        line_d = parity_q;
        if (bit_end) state_d = StStop1;
      end
`endif
      StStop1: begin
        if (bit_end) state_d = StStop2;
      end
      StStop2: begin
        if (bit_end) begin
          if (!empty) begin
            // Back-to-back: reload straight into the start bit, no idle gap.
            pop     = 1'b1;
            shift_d = head;
            state_d = StStart;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      // Line level follows the current state one clock later; every bit keeps DIV clocks.
      txd_q    <= line_d;
      // Covers the pushed byte immediately and stays up until the last stop bit leaves txd.
      busy_q   <= push | ~empty | (state_q != StIdle);
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH_LOG2 = 4;
  // (25_000_000 + 57_600) / 115_200 = 217
  localparam int unsigned DIV = 217;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME = 12 * DIV;  // 2604
`else
  localparam int unsigned FRAME = 11 * DIV;  // 2387
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          in_data = 8'h00;
  logic                in_valid = 1'b0;
  logic                in_ready, txd, busy;
  logic [DEPTH_LOG2:0] fifo_count;

  uart_tx_fifo #(
    .CLK_FREQ  (25000000),
    .BAUD      (115200),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .txd       (txd),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #20 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  exp_q[$];
  int unsigned starts[$];
  bit          abort_frame = 1'b0;
  int unsigned last_push;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
  endtask

  // Called just after a rising edge; drives for exactly one edge.
  task automatic push(input logic [7:0] b, input bit exp_accept);
    check("in_ready", 32'(in_ready), 32'(exp_accept));
    in_data  = b;
    in_valid = 1'b1;
    if (exp_accept) exp_q.push_back(b);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    last_push = cyc;
  endtask

  task automatic wait_starts(input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (starts.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (starts.size() < n) check("frame_timeout", 32'(starts.size()), 32'(n));
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Line monitor: decodes frames at bit centres and compares against the scoreboard.
  initial begin : monitor
    logic [7:0]  rx, e;
    logic        start_b, par_b, s1, s2;
    forever begin
      @(negedge clk);
      if (rst_n && txd === 1'b0) begin
        starts.push_back(cyc);
        repeat (DIV / 2) @(negedge clk);
        start_b = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          rx[i] = txd;
        end
        par_b = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        par_b = txd;
`endif
        repeat (DIV) @(negedge clk);
        s1 = txd;
        repeat (DIV) @(negedge clk);
        s2 = txd;
        if (abort_frame) begin
          abort_frame = 1'b0;
        end else if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(rx), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rx_byte", 32'(rx), 32'(e));
          check("start_bit", 32'(start_b), 32'd0);
          check("stop_bits", 32'({s1, s2}), 32'd3);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", 32'(par_b), 32'(^e));
`endif
        end
      end
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int unsigned base, p, busy_fall, k, lows;

    // Reset and idle.
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("idle_txd", 32'(txd), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_count", 32'(fifo_count), 32'd0);

    // Single byte 0x41.
    base = starts.size();
    push(8'h41, 1'b1);
    p = last_push;
    check("busy_rise", 32'(busy), 32'd1);
    wait_starts(base + 1, 10);
    if (starts.size() > base) begin
      check("latency", starts[base] - p, 32'd2);
      k = 0;
      while (busy && k < FRAME + 50) begin
        @(posedge clk);
        #1;
        k++;
      end
      busy_fall = cyc;
      check("busy_fall", busy_fall - starts[base], FRAME);
    end
    wait_idle(FRAME + 50);

    // Burst 0x00..0x11 every clock: 17 accepted, 18th refused.
    base = starts.size();
    for (int i = 0; i < 18; i++) push(8'(i), i < 17);
    check("full_count", 32'(fifo_count), 32'd16);
    wait_starts(base + 17, 17 * FRAME + 100);
    for (int i = 1; i < 17; i++) begin
      if (starts.size() > base + i) check("b2b_gap", starts[base+i] - starts[base+i-1], FRAME);
    end
    wait_idle(2 * FRAME);

    // Push on the exact edge STOP2 ends with one byte queued.
    base = starts.size();
    push(8'h3C, 1'b1);
    push(8'hC3, 1'b1);
    check("simul_pre_count", 32'(fifo_count), 32'd1);
    repeat (FRAME - 1) @(posedge clk);
    #1;
    check("simul_mid_count", 32'(fifo_count), 32'd1);
    push(8'h96, 1'b1);
    check("simul_post_count", 32'(fifo_count), 32'd1);
    wait_starts(base + 3, 3 * FRAME + 100);
    if (starts.size() >= base + 3) begin
      check("simul_gap1", starts[base+1] - starts[base], FRAME);
      check("simul_gap2", starts[base+2] - starts[base+1], FRAME);
    end
    wait_idle(3 * FRAME);

    // Mid-frame reset during bit 3 of 0xA5, with a second byte still queued.
    base = starts.size();
    push(8'hA5, 1'b1);
    push(8'h5A, 1'b1);
    exp_q.delete();
    abort_frame = 1'b1;
    repeat (4 * DIV + DIV / 2) @(posedge clk);
    #5;
    check("bit3_level", 32'(txd), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_txd", 32'(txd), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    lows = 0;
    repeat (FRAME + DIV) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("residual_line", lows, 32'd0);
    check("residual_frames", 32'(starts.size()), 32'(base + 1));

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 -> 1, 0x03 -> 0, frames back to back.
    base = starts.size();
    push(8'h07, 1'b1);
    push(8'h03, 1'b1);
    wait_starts(base + 2, 2 * FRAME + 100);
    if (starts.size() >= base + 2) check("parity_frame_len", starts[base+1] - starts[base], 32'd2604);
    wait_idle(2 * FRAME);
`endif

    wait_idle(FRAME);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
